// File: rtl/alu_control_pipe_if.sv
// rtl/alu_control_pipe_if.sv - decode-side request and decoded-op response bundle for alu_control_pipe
interface alu_control_pipe_if #(
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              stall;
  logic              flush;
  logic [1:0]        aluOp;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic              out_valid;
  logic [CTRL_W-1:0] aluControlOut;
  logic              illegal;
  logic [CNT_W-1:0]  illegal_count;

  modport master (
    output in_valid, stall, flush, aluOp, funct3, funct7,
    input  out_valid, aluControlOut, illegal, illegal_count
  );

  modport slave (
    input  in_valid, stall, flush, aluOp, funct3, funct7,
    output out_valid, aluControlOut, illegal, illegal_count
  );
endinterface

// File: rtl/alu_control_pipe.sv
// rtl/alu_control_pipe.sv - pipelined RV32I ALU control decoder with illegal-op flagging and counting
module alu_control_pipe #(
  parameter int STAGES = 1,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 16
) (
  input logic               clk,
  input logic               rst,
  alu_control_pipe_if.slave bus
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [3:0] dec_code;
  logic       dec_ill;

  // Illegal encodings decode to ADD with the flag set
  always_comb begin
    dec_code = OP_ADD;
    dec_ill  = 1'b0;
    unique case (bus.aluOp)
      2'b00: dec_code = OP_ADD;
      2'b01: begin
        unique case (bus.funct3)
          3'b000, 3'b001: dec_code = OP_SUB;
          3'b100, 3'b101: dec_code = OP_SLT;
          3'b110, 3'b111: dec_code = OP_SLTU;
          default:        dec_ill  = 1'b1;
        endcase
      end
      2'b10: begin
        if (bus.funct7 == F7_BASE) begin
          unique case (bus.funct3)
            3'b000: dec_code = OP_ADD;
            3'b001: dec_code = OP_SLL;
            3'b010: dec_code = OP_SLT;
            3'b011: dec_code = OP_SLTU;
            3'b100: dec_code = OP_XOR;
            3'b101: dec_code = OP_SRL;
            3'b110: dec_code = OP_OR;
            default: dec_code = OP_AND;
          endcase
        end else if (bus.funct7 == F7_ALT && bus.funct3 == 3'b000) begin
          dec_code = OP_SUB;
        end else if (bus.funct7 == F7_ALT && bus.funct3 == 3'b101) begin
          dec_code = OP_SRA;
        end else begin
          dec_ill = 1'b1;
        end
      end
      default: begin
        unique case (bus.funct3)
          3'b000: dec_code = OP_ADD;
          3'b010: dec_code = OP_SLT;
          3'b011: dec_code = OP_SLTU;
          3'b100: dec_code = OP_XOR;
          3'b110: dec_code = OP_OR;
          3'b111: dec_code = OP_AND;
          3'b001: begin
            if (bus.funct7 == F7_BASE) dec_code = OP_SLL;
            else                       dec_ill  = 1'b1;
          end
          default: begin
            if (bus.funct7 == F7_BASE)     dec_code = OP_SRL;
            else if (bus.funct7 == F7_ALT) dec_code = OP_SRA;
            else                           dec_ill  = 1'b1;
          end
        endcase
      end
    endcase
  end

  logic              vld_q     [STAGES];
  logic [CTRL_W-1:0] code_q    [STAGES];
  logic              ill_q     [STAGES];
  logic              feed_v    [STAGES];
  logic [CTRL_W-1:0] feed_code [STAGES];
  logic              feed_ill  [STAGES];
  logic [CNT_W-1:0]  cnt_q;
  logic              advance;

  assign advance      = !bus.flush && !bus.stall;
  assign feed_v[0]    = bus.in_valid;
  assign feed_code[0] = CTRL_W'(dec_code);
  assign feed_ill[0]  = dec_ill;

  for (genvar g = 1; g < STAGES; g++) begin : g_feed
    assign feed_v[g]    = vld_q[g-1];
    assign feed_code[g] = code_q[g-1];
    assign feed_ill[g]  = ill_q[g-1];
  end

  // Payloads only move with a valid entry, so bubbles never overwrite held data
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q[g]  <= 1'b0;
        code_q[g] <= '0;
        ill_q[g]  <= 1'b0;
      end else if (bus.flush) begin
        vld_q[g] <= 1'b0;
      end else if (!bus.stall) begin
        vld_q[g] <= feed_v[g];
        if (feed_v[g]) begin
          code_q[g] <= feed_code[g];
          ill_q[g]  <= feed_ill[g];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (advance && feed_v[STAGES-1] && feed_ill[STAGES-1] &&
                 cnt_q != {CNT_W{1'b1}}) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.out_valid     = vld_q[STAGES-1];
  assign bus.aluControlOut = code_q[STAGES-1];
  assign bus.illegal       = ill_q[STAGES-1];
  assign bus.illegal_count = cnt_q;

endmodule

// File: tb/tb_alu_control_pipe.sv
// tb/tb_alu_control_pipe.sv - bench for alu_control_pipe at STAGES 1/3/2 with a reference pipeline model
module tb_alu_control_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, stall, flush;
  logic [1:0] aluOp;
  logic [2:0] funct3;
  logic [6:0] funct7;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_control_pipe_if #(.CTRL_W(4), .CNT_W(16)) i1 ();
  alu_control_pipe_if #(.CTRL_W(4), .CNT_W(16)) i3 ();
  alu_control_pipe_if #(.CTRL_W(4), .CNT_W(2))  ic ();

  assign i1.in_valid = in_valid; assign i1.stall = stall; assign i1.flush = flush;
  assign i1.aluOp = aluOp; assign i1.funct3 = funct3; assign i1.funct7 = funct7;
  assign i3.in_valid = in_valid; assign i3.stall = stall; assign i3.flush = flush;
  assign i3.aluOp = aluOp; assign i3.funct3 = funct3; assign i3.funct7 = funct7;
  assign ic.in_valid = in_valid; assign ic.stall = stall; assign ic.flush = flush;
  assign ic.aluOp = aluOp; assign ic.funct3 = funct3; assign ic.funct7 = funct7;

  alu_control_pipe #(.STAGES(1), .CTRL_W(4), .CNT_W(16)) dut1 (.clk(clk), .rst(rst), .bus(i1));
  alu_control_pipe #(.STAGES(3), .CTRL_W(4), .CNT_W(16)) dut3 (.clk(clk), .rst(rst), .bus(i3));
  alu_control_pipe #(.STAGES(2), .CTRL_W(4), .CNT_W(2))  dutc (.clk(clk), .rst(rst), .bus(ic));

  // Reference model: per-DUT list of in-flight entries, index 0 nearest the input
  int        ns[3]   = '{1, 3, 2};
  int        cmax[3] = '{65535, 65535, 3};
  bit        mv[3][3];
  bit [3:0]  mc[3][3];
  bit        mi[3][3];
  int        mcnt[3];

  function automatic void ref_dec(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                  output bit [3:0] c, output bit il);
    bit [3:0] rt[8] = '{4'd2, 4'd4, 4'd8, 4'd9, 4'd3, 4'd5, 4'd1, 4'd0};
    bit [3:0] bt[4] = '{4'd6, 4'd2, 4'd8, 4'd9};
    c  = 4'd2;
    il = 1'b0;
    if (op == 2'd1) begin
      if (f3[2:1] == 2'b01) il = 1'b1;
      else                  c  = bt[f3[2:1]];
    end else if (op == 2'd2) begin
      if (f7 == 7'h00)                  c  = rt[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) c = 4'd6;
      else if (f7 == 7'h20 && f3 == 3'd5) c = 4'd7;
      else                              il = 1'b1;
    end else if (op == 2'd3) begin
      if (f3 == 3'd1 || f3 == 3'd5) begin
        if (f7 == 7'h00)                  c  = rt[f3];
        else if (f7 == 7'h20 && f3 == 3'd5) c = 4'd7;
        else                              il = 1'b1;
      end else begin
        c = rt[f3];
      end
    end
  endfunction

  task automatic model_update();
    bit [3:0] rc;
    bit       ri;
    bit       arr_v, arr_i;
    ref_dec(aluOp, funct3, funct7, rc, ri);
    for (int d = 0; d < 3; d++) begin
      int s = ns[d];
      if (rst) begin
        for (int k = 0; k < 3; k++) begin mv[d][k] = 0; mc[d][k] = 0; mi[d][k] = 0; end
        mcnt[d] = 0;
      end else if (flush) begin
        for (int k = 0; k < 3; k++) mv[d][k] = 0;
      end else if (!stall) begin
        arr_v = (s == 1) ? in_valid : mv[d][s-2];
        arr_i = (s == 1) ? ri : mi[d][s-2];
        if (arr_v && arr_i && mcnt[d] < cmax[d]) mcnt[d]++;
        for (int k = s - 1; k >= 1; k--) begin
          if (mv[d][k-1]) begin mc[d][k] = mc[d][k-1]; mi[d][k] = mi[d][k-1]; end
          mv[d][k] = mv[d][k-1];
        end
        if (in_valid) begin mc[d][0] = rc; mi[d][0] = ri; end
        mv[d][0] = in_valid;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] av, ac, ai, an;
    for (int d = 0; d < 3; d++) begin
      case (d)
        0: begin av = 32'(i1.out_valid); ac = 32'(i1.aluControlOut); ai = 32'(i1.illegal); an = 32'(i1.illegal_count); end
        1: begin av = 32'(i3.out_valid); ac = 32'(i3.aluControlOut); ai = 32'(i3.illegal); an = 32'(i3.illegal_count); end
        default: begin av = 32'(ic.out_valid); ac = 32'(ic.aluControlOut); ai = 32'(ic.illegal); an = 32'(ic.illegal_count); end
      endcase
      chk($sformatf("model_d%0d_valid", d), av, 32'(mv[d][ns[d]-1]));
      chk($sformatf("model_d%0d_code", d),  ac, 32'(mc[d][ns[d]-1]));
      chk($sformatf("model_d%0d_ill", d),   ai, 32'(mi[d][ns[d]-1]));
      chk($sformatf("model_d%0d_cnt", d),   an, 32'(mcnt[d]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic set_op(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7);
    aluOp = op; funct3 = f3; funct7 = f7;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] code;
    logic       ill;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [3:0] code, input logic ill);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.code = code; v.ill = ill;
    return v;
  endfunction

  vec_t       vecs[$];
  logic [3:0] got[$];

  initial begin
    vecs.push_back(mk(2'd2, 3'd5, 7'h20, 4'b0111, 1'b0));
    vecs.push_back(mk(2'd2, 3'd0, 7'h20, 4'b0110, 1'b0));
    vecs.push_back(mk(2'd2, 3'd0, 7'h00, 4'b0010, 1'b0));
    vecs.push_back(mk(2'd2, 3'd1, 7'h00, 4'b0100, 1'b0));
    vecs.push_back(mk(2'd2, 3'd2, 7'h00, 4'b1000, 1'b0));
    vecs.push_back(mk(2'd2, 3'd3, 7'h00, 4'b1001, 1'b0));
    vecs.push_back(mk(2'd2, 3'd4, 7'h00, 4'b0011, 1'b0));
    vecs.push_back(mk(2'd2, 3'd5, 7'h00, 4'b0101, 1'b0));
    vecs.push_back(mk(2'd2, 3'd6, 7'h00, 4'b0001, 1'b0));
    vecs.push_back(mk(2'd2, 3'd7, 7'h00, 4'b0000, 1'b0));
    vecs.push_back(mk(2'd2, 3'd0, 7'h01, 4'b0010, 1'b1));
    vecs.push_back(mk(2'd2, 3'd3, 7'h20, 4'b0010, 1'b1));
    vecs.push_back(mk(2'd0, 3'd5, 7'h7f, 4'b0010, 1'b0));
    vecs.push_back(mk(2'd1, 3'd0, 7'h33, 4'b0110, 1'b0));
    vecs.push_back(mk(2'd1, 3'd1, 7'h00, 4'b0110, 1'b0));
    vecs.push_back(mk(2'd1, 3'd4, 7'h00, 4'b1000, 1'b0));
    vecs.push_back(mk(2'd1, 3'd5, 7'h7f, 4'b1000, 1'b0));
    vecs.push_back(mk(2'd1, 3'd6, 7'h00, 4'b1001, 1'b0));
    vecs.push_back(mk(2'd1, 3'd7, 7'h00, 4'b1001, 1'b0));
    vecs.push_back(mk(2'd1, 3'd2, 7'h00, 4'b0010, 1'b1));
    vecs.push_back(mk(2'd1, 3'd3, 7'h00, 4'b0010, 1'b1));
    vecs.push_back(mk(2'd3, 3'd0, 7'h55, 4'b0010, 1'b0));
    vecs.push_back(mk(2'd3, 3'd2, 7'h7f, 4'b1000, 1'b0));
    vecs.push_back(mk(2'd3, 3'd3, 7'h00, 4'b1001, 1'b0));
    vecs.push_back(mk(2'd3, 3'd4, 7'h00, 4'b0011, 1'b0));
    vecs.push_back(mk(2'd3, 3'd6, 7'h00, 4'b0001, 1'b0));
    vecs.push_back(mk(2'd3, 3'd7, 7'h00, 4'b0000, 1'b0));
    vecs.push_back(mk(2'd3, 3'd1, 7'h00, 4'b0100, 1'b0));
    vecs.push_back(mk(2'd3, 3'd1, 7'h20, 4'b0010, 1'b1));
    vecs.push_back(mk(2'd3, 3'd5, 7'h00, 4'b0101, 1'b0));
    vecs.push_back(mk(2'd3, 3'd5, 7'h20, 4'b0111, 1'b0));
    vecs.push_back(mk(2'd3, 3'd5, 7'h01, 4'b0010, 1'b1));

    set_op(2'd0, 3'd0, 7'd0);
    rst = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_valid", 32'(i1.out_valid), 0);
    chk("reset_code",  32'(i1.aluControlOut), 0);
    chk("reset_ill",   32'(i1.illegal), 0);
    chk("reset_cnt",   32'(i1.illegal_count), 0);

    foreach (vecs[i]) begin
      set_op(vecs[i].op, vecs[i].f3, vecs[i].f7);
      in_valid = 1'b1;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(i1.out_valid), 1);
      chk($sformatf("vec%0d_code", i),  32'(i1.aluControlOut), 32'(vecs[i].code));
      chk($sformatf("vec%0d_ill", i),   32'(i1.illegal), 32'(vecs[i].ill));
    end
    in_valid = 1'b0;

    // illegal counting and saturation at CNT_W=2
    do_reset();
    set_op(2'd2, 3'd0, 7'h01);
    in_valid = 1'b1;
    tick();
    chk("ill_one_code", 32'(i1.aluControlOut), 32'b0010);
    chk("ill_one_flag", 32'(i1.illegal), 1);
    chk("ill_one_cnt",  32'(i1.illegal_count), 1);
    for (int k = 0; k < 4; k++) tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("ill_five_cnt16", 32'(i1.illegal_count), 5);
    chk("ill_sat_cnt2",   32'(ic.illegal_count), 3);

    // STAGES=3 back-to-back ADD, SUB, AND
    do_reset();
    in_valid = 1'b1;
    set_op(2'd0, 3'd0, 7'h00); tick();
    set_op(2'd1, 3'd0, 7'h00); tick();
    set_op(2'd2, 3'd7, 7'h00); tick();
    chk("b2b_e2_valid", 32'(i3.out_valid), 1);
    chk("b2b_e2_code",  32'(i3.aluControlOut), 32'b0010);
    in_valid = 1'b0;
    tick();
    chk("b2b_e3_code",  32'(i3.aluControlOut), 32'b0110);
    tick();
    chk("b2b_e4_code",  32'(i3.aluControlOut), 32'b0000);
    chk("b2b_e4_valid", 32'(i3.out_valid), 1);

    // same stream with a 2-cycle stall while AND waits upstream
    do_reset();
    got.delete();
    in_valid = 1'b1;
    for (int e = 0; e < 12; e++) begin
      logic stall_at_edge;
      case (e)
        0: set_op(2'd0, 3'd0, 7'h00);
        1: set_op(2'd1, 3'd0, 7'h00);
        2: begin set_op(2'd2, 3'd7, 7'h00); stall = 1'b1; end
        4: stall = 1'b0;
        5: in_valid = 1'b0;
        default: ;
      endcase
      stall_at_edge = stall;
      tick();
      if (!stall_at_edge && i3.out_valid) got.push_back(i3.aluControlOut);
      if (e == 4) chk("stall_shift_first", 32'(i3.out_valid), 1);
    end
    chk("stall_count", 32'(got.size()), 3);
    if (got.size() == 3) begin
      chk("stall_o0", 32'(got[0]), 32'b0010);
      chk("stall_o1", 32'(got[1]), 32'b0110);
      chk("stall_o2", 32'(got[2]), 32'b0000);
    end

    // flush with an illegal op in stage 2
    do_reset();
    set_op(2'd2, 3'd0, 7'h01);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("flush_valid%0d", k), 32'(i3.out_valid), 0);
      chk($sformatf("flush_cnt%0d", k),   32'(i3.illegal_count), 0);
    end

    // flush wins over stall
    do_reset();
    set_op(2'd0, 3'd0, 7'h00);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b1; stall = 1'b1;
    tick();
    flush = 1'b0; stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("flushstall_valid%0d", k), 32'(i3.out_valid), 0);
    end

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [6:0] f7_pick[3];
      f7_pick[0] = 7'h00;
      f7_pick[1] = 7'h20;
      f7_pick[2] = 7'($urandom);
      rst      = ($urandom_range(0, 59) == 0);
      stall    = ($urandom_range(0, 4) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      set_op(2'($urandom), 3'($urandom), f7_pick[$urandom_range(0, 2)]);
      tick();
    end
    rst = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b1;
    set_op(2'd1, 3'd2, 7'h00);
    for (int n = 0; n < 8; n++) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_control_pipe.md
# alu_control_pipe

Pipelined, parametrised ALU control decoder for the RV32I datapath. It takes `aluOp`/`funct3`/`funct7` from the decode stage and produces a registered ALU operation code. Compared with the single-register decoder, it covers the full RV32I integer op set, flags illegal encodings, and honours pipeline stall/flush. It sits between the main control unit and the ALU and carries a valid bit alongside each decoded op.

## Interface
Parameters:
- `STAGES`, default 1: number of register stages, legal range 1..3.
- `CTRL_W`, default 4: width of `aluControlOut`, minimum 4; codes are zero-extended.
- `CNT_W`, default 16: width of the illegal-op counter.

Ports:
- `clk` input, 1: single clock; all state updates on its rising edge.
- `rst` input, 1: reset; synchronous, active-high.
- `in_valid` input, 1: the current `aluOp`/`funct3`/`funct7` belong to a real instruction.
- `stall` input, 1: hold every stage; inputs are not sampled.
- `flush` input, 1: drop all in-flight entries.
- `aluOp` input, 2: 00 load/store, 01 branch, 10 R-type, 11 I-type ALU.
- `funct3` input, 3: instruction funct3.
- `funct7` input, 7: instruction funct7 (imm[11:5] for I-type).
- `out_valid` output, 1: `aluControlOut`/`illegal` hold a decoded op.
- `aluControlOut` output, CTRL_W: ALU operation code.
- `illegal` output, 1: the decoded op was an illegal encoding.
- `illegal_count` output, CNT_W: saturating count of illegal ops delivered at the output.

## Operation
- Codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, SLT 1000, SLTU 1001.
- `aluOp`=00: ADD for any funct3/funct7.
- `aluOp`=01, by funct3:
  - 000/001 → SUB
  - 100/101 → SLT
  - 110/111 → SLTU
  - 010/011 → illegal
  - funct7 is ignored.
- `aluOp`=10:
  - funct7=0000000, by funct3: 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - funct7=0100000: funct3 000 → SUB, 101 → SRA, anything else → illegal.
  - Any other funct7 → illegal.
- `aluOp`=11, by funct3 (funct7 ignored unless stated):
  - 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - 001 → SLL only if funct7=0000000, else illegal.
  - 101 → SRL if funct7=0000000, SRA if funct7=0100000, else illegal.
- Illegal encoding: `aluControlOut` = ADD code, `illegal`=1. There is no hold-last-value behaviour.
- Pipeline is a chain of STAGES (valid, code, illegal) registers.
  - Stage 1 loads the decode of the inputs.
  - Stage k loads from stage k-1.
  - The last stage drives the outputs.
- Advance (stall=0, flush=0):
  - Each valid bit takes its predecessor's value; stage 1 takes `in_valid`.
  - A payload loads only when the incoming valid is 1; otherwise it holds.
- Stall (stall=1, flush=0): all registers and the counter hold.
- Flush (flush=1, regardless of stall): all valid bits clear on the next edge; payloads hold; the counter holds.
- `illegal_count`:
  - +1 on each edge where the last stage loads a valid entry with illegal=1.
  - Saturates at 2^CNT_W−1.
  - Entries flushed before reaching the last stage are not counted.
- Reset (`rst`=1, highest priority): all valid bits 0, `aluControlOut`=0, `illegal`=0, `illegal_count`=0. Internal payloads are cleared as well.

## Timing
- Latency is STAGES cycles. An input sampled at edge N with stall=0 appears with `out_valid`=1 after edge N+STAGES−1.
- Throughput is one op per cycle when `stall`=0.
- `illegal_count` updates on the same edge that presents the illegal op at the output.
- Reset mid-stream: everything is cleared on the edge; inputs on that edge are discarded.
- Stall with in_valid=1: the instruction is not captured. The upstream stage must hold it until stall drops.
- Flush and in_valid on the same edge: the input is dropped.
- No combinational path from inputs to outputs.

## Test plan
- Reset: rst=1 for 2 cycles → out_valid=0, aluControlOut=0, illegal=0, illegal_count=0.
- STAGES=1, R-type sweep: aluOp=10, funct7=0100000, funct3=101 → next cycle out_valid=1, aluControlOut=0111, illegal=0. Also cover all legal R/I/branch codes.
- Illegal: aluOp=10, funct7=0000001, funct3=000 → aluControlOut=0010, illegal=1, illegal_count=1. Repeat with CNT_W=2 for 5 ops → count saturates at 3.
- STAGES=3, back-to-back: ADD, SUB, AND issued on edges 0–2 → outputs 0010, 0110, 0000 after edges 2–4. Raising stall for 2 cycles mid-stream shifts them by 2 with no loss or duplication.
- STAGES=3, illegal op in stage 2 plus flush=1 → out_valid stays 0 for 3 cycles and illegal_count is unchanged. flush=1 together with stall=1 still empties the pipe.
- I-type shift: aluOp=11, funct3=001, funct7=0100000 → illegal=1. With funct3=101, funct7=0100000 → aluControlOut=0111.
